// File: rtl/unidade_de_busca.sv
// -----------------------------------------------------------------------------
// unidade_de_busca
// Instruction-fetch sequencer for the single-cycle iZero MIPS processor.
// Holds the program counter and computes the next PC from the current
// instruction word, the branch outcome and the jr register value. It also
// tracks the processor run state: running, waiting for user input (in),
// halted, or address error.
//
// Ports:
//   clock             system clock, rising edge
//   reset             synchronous, active-low reset
//   instrucao         instruction word at the current pc (combinational fetch)
//   desvio_tomado     branch condition for the current bne/blt
//   endereco_jr       register value used as the jr target
//   confirmar         user confirm button (level, already synchronised)
//   pc                registered program counter
//   pc_mais_um        pc + 1, the jal return address
//   habilita_escrita  current instruction may commit its writes (Mealy)
//   esperando_entrada high while waiting for the confirm button
//   parado            high when halted or in address error
//   erro_endereco     high in address error
// -----------------------------------------------------------------------------
module unidade_de_busca #(
  parameter int TAM_MEMORIA = 72,
  parameter int PC_INICIAL  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instrucao,
  input  logic        desvio_tomado,
  input  logic [25:0] endereco_jr,
  input  logic        confirmar,
  output logic [25:0] pc,
  output logic [25:0] pc_mais_um,
  output logic        habilita_escrita,
  output logic        esperando_entrada,
  output logic        parado,
  output logic        erro_endereco
);

  localparam logic [1:0] EXECUTANDO = 2'd0;
  localparam logic [1:0] ESPERA     = 2'd1;
  localparam logic [1:0] PARADO     = 2'd2;
  localparam logic [1:0] ERRO       = 2'd3;

  localparam logic [5:0] OP_BNE  = 6'b011000;
  localparam logic [5:0] OP_BLT  = 6'b011001;
  localparam logic [5:0] OP_J    = 6'b011101;
  localparam logic [5:0] OP_JAL  = 6'b011110;
  localparam logic [5:0] OP_JR   = 6'b011111;
  localparam logic [5:0] OP_IN   = 6'b100000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [25:0] LIMITE_C  = 26'(TAM_MEMORIA);
  localparam logic [25:0] PC_RESET_C = 26'(PC_INICIAL);

  logic [1:0]  estado_r;
  logic [1:0]  estado_prox_s;
  logic [25:0] pc_r;
  logic [25:0] pc_prox_s;
  logic [25:0] pc_inc_s;
  logic [25:0] alvo_s;
  logic [5:0]  opcode_s;
  logic        confirmar_ant_r;
  logic        borda_s;
  logic        habilita_s;
  logic        esperando_r;
  logic        parado_r;
  logic        erro_r;

  assign opcode_s = instrucao[31:26];
  assign pc_inc_s = pc_r + 26'd1;
  assign borda_s  = confirmar & ~confirmar_ant_r;

  // Candidate next PC for an instruction executing in EXECUTANDO.
  always_comb begin
    alvo_s = pc_inc_s;
    case (opcode_s)
      OP_J, OP_JAL: alvo_s = instrucao[25:0];
      OP_JR:        alvo_s = endereco_jr;
      OP_BNE, OP_BLT: begin
        // Branch targets are absolute 16-bit word addresses.
        if (desvio_tomado) begin
          alvo_s = {10'b0, instrucao[15:0]};
        end else begin
          alvo_s = pc_inc_s;
        end
      end
      default:      alvo_s = pc_inc_s;
    endcase
  end

  // Next state, next PC and the Mealy write enable.
  always_comb begin
    estado_prox_s = estado_r;
    pc_prox_s     = pc_r;
    habilita_s    = 1'b0;
    case (estado_r)
      EXECUTANDO: begin
        if (opcode_s == OP_HALT) begin
          estado_prox_s = PARADO;
        end else if (opcode_s == OP_IN) begin
          estado_prox_s = ESPERA;
        end else begin
          // An out-of-range target still lets the current instruction commit.
          habilita_s = 1'b1;
          if (alvo_s >= LIMITE_C) begin
            estado_prox_s = ERRO;
          end else begin
            pc_prox_s = alvo_s;
          end
        end
      end
      ESPERA: begin
        if (borda_s) begin
          habilita_s = 1'b1;
          if (pc_inc_s >= LIMITE_C) begin
            estado_prox_s = ERRO;
          end else begin
            estado_prox_s = EXECUTANDO;
            pc_prox_s     = pc_inc_s;
          end
        end else begin
          habilita_s = 1'b0;
        end
      end
      PARADO:  estado_prox_s = PARADO;
      ERRO:    estado_prox_s = ERRO;
      default: estado_prox_s = ERRO;
    endcase
  end

  // State, PC, edge-detector history and registered status flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_r        <= EXECUTANDO;
      pc_r            <= PC_RESET_C;
      // Treat a button held through reset as already pressed.
      confirmar_ant_r <= 1'b1;
      esperando_r     <= 1'b0;
      parado_r        <= 1'b0;
      erro_r          <= 1'b0;
    end else begin
      estado_r        <= estado_prox_s;
      pc_r            <= pc_prox_s;
      confirmar_ant_r <= confirmar;
      esperando_r     <= (estado_prox_s == ESPERA);
      parado_r        <= (estado_prox_s == PARADO) || (estado_prox_s == ERRO);
      erro_r          <= (estado_prox_s == ERRO);
    end
  end

  assign pc                = pc_r;
  assign pc_mais_um        = pc_inc_s;
  assign habilita_escrita  = habilita_s;
  assign esperando_entrada = esperando_r;
  assign parado            = parado_r;
  assign erro_endereco     = erro_r;

endmodule

// File: tb/tb_unidade_de_busca.sv
module tb_unidade_de_busca;

  logic        clock;
  logic        reset;
  logic [31:0] instrucao;
  logic        desvio_tomado;
  logic [25:0] endereco_jr;
  logic        confirmar;
  logic [25:0] pc;
  logic [25:0] pc_mais_um;
  logic        habilita_escrita;
  logic        esperando_entrada;
  logic        parado;
  logic        erro_endereco;

  int total;
  int bad;

  unidade_de_busca #(.TAM_MEMORIA(72), .PC_INICIAL(0)) dut (
    .clock             (clock),
    .reset             (reset),
    .instrucao         (instrucao),
    .desvio_tomado     (desvio_tomado),
    .endereco_jr       (endereco_jr),
    .confirmar         (confirmar),
    .pc                (pc),
    .pc_mais_um        (pc_mais_um),
    .habilita_escrita  (habilita_escrita),
    .esperando_entrada (esperando_entrada),
    .parado            (parado),
    .erro_endereco     (erro_endereco)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADDI = 32'h2000_0005;
  localparam logic [31:0] IN   = 32'h8000_0000;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    enc_j = {6'b011101, t};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [25:0] t);
    enc_jal = {6'b011110, t};
  endfunction
  function automatic logic [31:0] enc_br(input logic [5:0] op, input logic [9:0] hi, input logic [15:0] t);
    enc_br = {op, hi, t};
  endfunction

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    instrucao = NOP;
    step();
    reset = 1'b1;
  endtask

  // From any EXECUTANDO pc, jump to address t.
  task automatic goto(input logic [25:0] t);
    instrucao = enc_j(t);
    desvio_tomado = 1'b0;
    step();
  endtask

  task automatic test_reset();
    confirmar = 1'b0;
    reset = 1'b0;
    instrucao = enc_j(26'd40);
    step();
    total++; if (pc !== 26'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    total++; if (pc_mais_um !== 26'd1) begin bad++; $display("FAIL reset_pc_mais_um got=%0d exp=1", pc_mais_um); end
    total++; if ({esperando_entrada, parado, erro_endereco} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {esperando_entrada, parado, erro_endereco}); end
    reset = 1'b1;
    #1;
    total++; if (habilita_escrita !== 1'b1) begin bad++; $display("FAIL j40_habilita got=%b exp=1", habilita_escrita); end
    step();
    total++; if (pc !== 26'd40) begin bad++; $display("FAIL j40_pc got=%0d exp=40", pc); end
  endtask

  task automatic test_sequential();
    instrucao = ADDI;
    step();
    total++; if (pc !== 26'd41) begin bad++; $display("FAIL seq1_pc got=%0d exp=41", pc); end
    step();
    total++; if (pc !== 26'd42) begin bad++; $display("FAIL seq2_pc got=%0d exp=42", pc); end
  endtask

  task automatic test_jal();
    goto(26'd52);
    instrucao = enc_jal(26'd1);
    #1;
    total++; if (pc_mais_um !== 26'd53) begin bad++; $display("FAIL jal_pc_mais_um got=%0d exp=53", pc_mais_um); end
    total++; if (habilita_escrita !== 1'b1) begin bad++; $display("FAIL jal_habilita got=%b exp=1", habilita_escrita); end
    step();
    total++; if (pc !== 26'd1) begin bad++; $display("FAIL jal_pc got=%0d exp=1", pc); end
  endtask

  task automatic test_branch();
    goto(26'd8);
    instrucao = enc_br(6'b011001, 10'd0, 16'd39);
    desvio_tomado = 1'b1;
    step();
    total++; if (pc !== 26'd39) begin bad++; $display("FAIL blt_taken_pc got=%0d exp=39", pc); end
    goto(26'd8);
    instrucao = enc_br(6'b011001, 10'd0, 16'd39);
    desvio_tomado = 1'b0;
    step();
    total++; if (pc !== 26'd9) begin bad++; $display("FAIL blt_not_taken_pc got=%0d exp=9", pc); end
    // Bits 25:16 of a branch word do not reach the target.
    instrucao = enc_br(6'b011000, 10'h3FF, 16'd5);
    desvio_tomado = 1'b1;
    step();
    total++; if (pc !== 26'd5) begin bad++; $display("FAIL bne_taken_pc got=%0d exp=5", pc); end
    desvio_tomado = 1'b0;
  endtask

  task automatic test_in();
    goto(26'd20);
    instrucao = IN;
    confirmar = 1'b1;
    #1;
    total++; if (habilita_escrita !== 1'b0) begin bad++; $display("FAIL in_entry_habilita got=%b exp=0", habilita_escrita); end
    step();
    total++; if (esperando_entrada !== 1'b1) begin bad++; $display("FAIL in_esperando got=%b exp=1", esperando_entrada); end
    for (int i = 0; i < 5; i++) begin
      total++; if (pc !== 26'd20 || habilita_escrita !== 1'b0) begin bad++; $display("FAIL in_hold pc=%0d hab=%b exp pc=20 hab=0", pc, habilita_escrita); end
      step();
    end
    confirmar = 1'b0;
    #1;
    total++; if (habilita_escrita !== 1'b0) begin bad++; $display("FAIL in_low_habilita got=%b exp=0", habilita_escrita); end
    step();
    confirmar = 1'b1;
    #1;
    total++; if (habilita_escrita !== 1'b1) begin bad++; $display("FAIL in_edge_habilita got=%b exp=1", habilita_escrita); end
    step();
    instrucao = NOP;
    total++; if (pc !== 26'd21) begin bad++; $display("FAIL in_done_pc got=%0d exp=21", pc); end
    total++; if (esperando_entrada !== 1'b0) begin bad++; $display("FAIL in_done_esperando got=%b exp=0", esperando_entrada); end
    confirmar = 1'b0;
  endtask

  task automatic test_reset_in_espera();
    goto(26'd30);
    instrucao = IN;
    step();
    confirmar = 1'b1;
    reset = 1'b0;
    step();
    reset = 1'b1;
    instrucao = NOP;
    total++; if (pc !== 26'd0 || esperando_entrada !== 1'b0) begin bad++; $display("FAIL reset_espera pc=%0d esp=%b exp pc=0 esp=0", pc, esperando_entrada); end
    confirmar = 1'b0;
  endtask

  task automatic test_halt();
    goto(26'd71);
    instrucao = HALT;
    #1;
    total++; if (habilita_escrita !== 1'b0) begin bad++; $display("FAIL halt_habilita got=%b exp=0", habilita_escrita); end
    step();
    total++; if (parado !== 1'b1 || erro_endereco !== 1'b0) begin bad++; $display("FAIL halt_flags parado=%b erro=%b exp 1 0", parado, erro_endereco); end
    instrucao = enc_j(26'd5);
    for (int i = 0; i < 10; i++) begin
      total++; if (pc !== 26'd71 || habilita_escrita !== 1'b0 || parado !== 1'b1) begin bad++; $display("FAIL halt_hold pc=%0d hab=%b parado=%b exp 71 0 1", pc, habilita_escrita, parado); end
      step();
    end
    do_reset();
    total++; if (pc !== 26'd0 || parado !== 1'b0) begin bad++; $display("FAIL halt_reset pc=%0d parado=%b exp 0 0", pc, parado); end
  endtask

  task automatic test_erro();
    goto(26'd71);
    instrucao = ADDI;
    #1;
    total++; if (habilita_escrita !== 1'b1) begin bad++; $display("FAIL erro_addi_habilita got=%b exp=1", habilita_escrita); end
    step();
    total++; if (erro_endereco !== 1'b1 || parado !== 1'b1 || pc !== 26'd71) begin bad++; $display("FAIL erro_addi erro=%b parado=%b pc=%0d exp 1 1 71", erro_endereco, parado, pc); end
    instrucao = enc_j(26'd3);
    #1;
    total++; if (habilita_escrita !== 1'b0) begin bad++; $display("FAIL erro_absorb_habilita got=%b exp=0", habilita_escrita); end
    step();
    total++; if (pc !== 26'd71 || erro_endereco !== 1'b1) begin bad++; $display("FAIL erro_absorb pc=%0d erro=%b exp 71 1", pc, erro_endereco); end
    do_reset();
    total++; if (erro_endereco !== 1'b0 || parado !== 1'b0) begin bad++; $display("FAIL erro_reset erro=%b parado=%b exp 0 0", erro_endereco, parado); end
    instrucao = 32'h7C00_0000;
    endereco_jr = 26'd100;
    #1;
    total++; if (habilita_escrita !== 1'b1) begin bad++; $display("FAIL jr_habilita got=%b exp=1", habilita_escrita); end
    step();
    total++; if (erro_endereco !== 1'b1 || pc !== 26'd0) begin bad++; $display("FAIL jr100 erro=%b pc=%0d exp 1 0", erro_endereco, pc); end
    do_reset();
    instrucao = 32'h7C00_0000;
    endereco_jr = 26'd71;
    step();
    total++; if (pc !== 26'd71 || erro_endereco !== 1'b0) begin bad++; $display("FAIL jr71 pc=%0d erro=%b exp 71 0", pc, erro_endereco); end
    instrucao = enc_j(26'd72);
    step();
    total++; if (erro_endereco !== 1'b1 || pc !== 26'd71) begin bad++; $display("FAIL j72 erro=%b pc=%0d exp 1 71", erro_endereco, pc); end
  endtask

  task automatic test_in_at_limit();
    do_reset();
    goto(26'd71);
    instrucao = IN;
    confirmar = 1'b0;
    step();
    confirmar = 1'b1;
    #1;
    total++; if (habilita_escrita !== 1'b1) begin bad++; $display("FAIL in71_habilita got=%b exp=1", habilita_escrita); end
    step();
    total++; if (erro_endereco !== 1'b1 || esperando_entrada !== 1'b0 || pc !== 26'd71) begin bad++; $display("FAIL in71 erro=%b esp=%b pc=%0d exp 1 0 71", erro_endereco, esperando_entrada, pc); end
    confirmar = 1'b0;
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    instrucao = NOP;
    desvio_tomado = 1'b0;
    endereco_jr = 26'd0;
    confirmar = 1'b0;
    total = 0;
    bad = 0;
    test_reset();
    test_sequential();
    test_jal();
    test_branch();
    test_in();
    test_reset_in_espera();
    test_halt();
    test_erro();
    test_in_at_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
